// File: rtl/c2sif_pkg.sv
// Shared codes for the c2sif request channel: function/return enums and the
// serial bridge FSM state encoding.
package c2sif_pkg;

  localparam int RET_W = 32;

  typedef enum logic [3:0] {
    FN_WR = 4'd0,
    FN_RW = 4'd1
  } fn_e;

  typedef enum logic [RET_W-1:0] {
    RET_OK      = 32'd0,
    RET_BAD_FN  = 32'd1,
    RET_BAD_LEN = 32'd2
  } ret_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_ACK,
    ST_SKIP
  } state_e;

endpackage

// File: rtl/c2sif_ser_tick.sv
// sclk phase divider: counts CLK_DIV cycles per phase and strobes phase_end on
// the last cycle of each phase, reloading itself for the next phase.
module c2sif_ser_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic phase_end
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (en) begin
      cnt_d = (cnt_q == '0) ? RELOAD : (cnt_q - DIV_W'(1));
    end
  end

  assign phase_end = en && !load && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= RELOAD;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/c2sif_ser_bridge.sv
// c2sif four-phase responder that turns an addressed request into an MSB-first
// serial transfer on sclk/din/dout and returns captured bits plus a status.
module c2sif_ser_bridge
  import c2sif_pkg::*;
#(
  parameter int ID      = 0,
  parameter int ID_W    = 8,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = $clog2(DATA_W + 1),
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ID_W-1:0]   id,
  input  logic [3:0]        fn,
  input  logic [LEN_W-1:0]  nbits,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [RET_W-1:0]  ret,
  output logic [DATA_W-1:0] rdata,
  output logic              sclk,
  output logic              din,
  input  logic              dout,
  output state_e            dbg_state
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [ID_W-1:0]  ID_MATCH = ID_W'(ID);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(DATA_W);

  state_e            state_q, state_d;
  logic              armed_q, armed_d;
  logic              viol_q, viol_d;
  logic              rw_q, rw_d;
  logic [LEN_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [RET_W-1:0]  ret_q, ret_d;
  logic              ack_q, ack_d;
  logic              sclk_q, sclk_d;
  logic              din_q, din_d;
  logic              tick_load, tick_en, phase_end;

  c2sif_ser_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .load      (tick_load),
    .en        (tick_en),
    .phase_end (phase_end)
  );

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q | ~req;
    viol_d    = viol_q;
    rw_d      = rw_q;
    bit_cnt_d = bit_cnt_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ret_d     = ret_q;
    tick_load = 1'b1;
    tick_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        viol_d = 1'b0;
        if (req && armed_q) begin
          armed_d = 1'b0;
          if (id == ID_MATCH) begin
            rdata_d   = '0;
            wdata_d   = wdata;
            rw_d      = (fn == FN_RW);
            bit_cnt_d = nbits - LEN_W'(1);
            if (fn != FN_WR && fn != FN_RW) begin
              ret_d   = RET_BAD_FN;
              state_d = ST_ACK;
            end else if (nbits == '0 || nbits > MAX_LEN) begin
              ret_d   = RET_BAD_LEN;
              state_d = ST_ACK;
            end else begin
              ret_d   = RET_OK;
              state_d = ST_SHIFT_LO;
            end
          end else begin
            state_d = ST_SKIP;
          end
        end
      end
      ST_SHIFT_LO: begin
        tick_load = 1'b0;
        tick_en   = 1'b1;
        if (!req) viol_d = 1'b1;
        if (phase_end) state_d = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        tick_load = 1'b0;
        tick_en   = 1'b1;
        if (!req) viol_d = 1'b1;
        // First HI cycle is the edge that raises sclk: sample dout here.
        if (!sclk_q && rw_q) rdata_d = {rdata_q[DATA_W-2:0], dout};
        if (phase_end) begin
          if (bit_cnt_q == '0) begin
            state_d = ST_ACK;
          end else begin
            bit_cnt_d = bit_cnt_q - LEN_W'(1);
            state_d   = ST_SHIFT_LO;
          end
        end
      end
      ST_ACK: begin
        // A requester that already dropped req gets a single-cycle ack.
        if (!req || viol_q) state_d = ST_IDLE;
      end
      ST_SKIP: begin
        if (!req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ack_d  = (state_q == ST_ACK);
    sclk_d = (state_q == ST_SHIFT_HI);
    din_d  = 1'b0;
    if (state_q == ST_SHIFT_LO || state_q == ST_SHIFT_HI)
      din_d = wdata_q[bit_cnt_q[IDX_W-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      armed_q   <= 1'b0;
      viol_q    <= 1'b0;
      rw_q      <= 1'b0;
      bit_cnt_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ret_q     <= '0;
      ack_q     <= 1'b0;
      sclk_q    <= 1'b0;
      din_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      viol_q    <= viol_d;
      rw_q      <= rw_d;
      bit_cnt_q <= bit_cnt_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ret_q     <= ret_d;
      ack_q     <= ack_d;
      sclk_q    <= sclk_d;
      din_q     <= din_d;
    end
  end

  assign ack       = ack_q;
  assign ret       = ret_q;
  assign rdata     = rdata_q;
  assign sclk      = sclk_q;
  assign din       = din_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_c2sif_ser_bridge.sv
// Randomised and directed bench for c2sif_ser_bridge against a transaction-level
// model of the expected serial bits, ack latency, status and captured data.
module tb_c2sif_ser_bridge;
  import c2sif_pkg::*;

  localparam int ID      = 3;
  localparam int ID_W    = 8;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = $clog2(DATA_W + 1);
  localparam int CLK_DIV = 2;
  localparam int TMO     = 2000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req = 1'b0;
  logic [ID_W-1:0]   id = '0;
  logic [3:0]        fn = '0;
  logic [LEN_W-1:0]  nbits = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic              dout = 1'b0;
  logic              ack;
  logic [RET_W-1:0]  ret;
  logic [DATA_W-1:0] rdata;
  logic              sclk;
  logic              din;
  state_e            dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];

  c2sif_ser_bridge #(
    .ID(ID), .ID_W(ID_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .id(id), .fn(fn), .nbits(nbits),
    .wdata(wdata), .ack(ack), .ret(ret), .rdata(rdata), .sclk(sclk),
    .din(din), .dout(dout), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic [31:0] model_ret(input logic [3:0] f, input int n);
    if (f > 4'd1) return 32'd1;
    if (n == 0 || n > DATA_W) return 32'd2;
    return 32'd0;
  endfunction

  function automatic int model_lat(input logic [3:0] f, input int n);
    if (model_ret(f, n) != 0) return 1;
    return 1 + 2 * CLK_DIV * n;
  endfunction

  function automatic logic [DATA_W-1:0] model_rdata(input logic [3:0] f, input int n,
                                                    input logic [31:0] bits);
    logic [DATA_W-1:0] r;
    r = '0;
    if (f == 4'd1 && model_ret(f, n) == 0)
      for (int i = 0; i < n; i++)
        if (bits[i]) r = r + (DATA_W'(1) << (n - 1 - i));
    return r;
  endfunction

  // driver: one full four-phase request; rbits[i] is what the DUT returns in bit period i
  task automatic run_req(input logic [ID_W-1:0] rid, input logic [3:0] rfn, input int rn,
                         input logic [31:0] rwd, input logic [31:0] rbits, input string tag);
    int rises;
    int got_lat;
    logic prev_sclk;
    int exp_n;
    exp_n = (model_ret(rfn, rn) == 0) ? rn : 0;
    exp_q.delete();
    for (int i = 0; i < exp_n; i++) exp_q.push_back(rwd[rn-1-i]);
    id = rid; fn = rfn; nbits = rn[LEN_W-1:0]; wdata = rwd; req = 1'b1;
    dout = rbits[0];
    rises = 0; got_lat = -1; prev_sclk = 1'b0;
    for (int e = 0; e < TMO; e++) begin
      @(posedge clk); #1;
      if (sclk && !prev_sclk) begin
        check($sformatf("%s_rise%0d_time", tag, rises), e, 1 + CLK_DIV * (2 * rises + 1));
        if (exp_q.size() > 0) check($sformatf("%s_din%0d", tag, rises), din, exp_q.pop_front());
        else check($sformatf("%s_extra_sclk", tag), 1, 0);
        rises++;
        dout = (rises < 32) ? rbits[rises] : 1'b0;
      end
      prev_sclk = sclk;
      if (ack) begin
        got_lat = e;
        break;
      end
    end
    check($sformatf("%s_ack_lat", tag), got_lat, model_lat(rfn, rn));
    check($sformatf("%s_ret", tag), ret, model_ret(rfn, rn));
    check($sformatf("%s_rdata", tag), rdata, model_rdata(rfn, rn, rbits));
    check($sformatf("%s_nrises", tag), rises, exp_n);
    req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check($sformatf("%s_ack_fall", tag), {ack, sclk, din}, 3'b000);
  endtask

  task automatic run_skip(input logic [ID_W-1:0] rid, input int cycles);
    logic busy;
    busy = 1'b0;
    id = rid; fn = 4'd0; nbits = LEN_W'(8); wdata = 32'hFF; req = 1'b1;
    for (int e = 0; e < cycles; e++) begin
      @(posedge clk); #1;
      if (ack || sclk || din) busy = 1'b1;
    end
    req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (ack || sclk) busy = 1'b1;
    check("skip_quiet", busy, 1'b0);
  endtask

  task automatic run_reset_abort();
    int rises;
    logic prev_sclk;
    logic busy;
    id = ID_W'(ID); fn = 4'd1; nbits = LEN_W'(16); wdata = $urandom(); req = 1'b1;
    dout = 1'b1;
    rises = 0; prev_sclk = 1'b0;
    for (int e = 0; e < TMO && rises < 4; e++) begin
      @(posedge clk); #1;
      if (sclk && !prev_sclk) rises++;
      prev_sclk = sclk;
    end
    check("abort_reached_bit3", rises, 4);
    #2 rst = 1'b0;
    #1;
    check("abort_outputs_zero", {ack, sclk, din, rdata, ret}, '0);
    check("abort_state_idle", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst = 1'b1;
    busy = 1'b0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (ack || sclk) busy = 1'b1;
    end
    check("abort_req_ignored", busy, 1'b0);
    req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  // req drops mid-transfer: transfer finishes and ack pulses exactly once
  task automatic run_violation();
    int ack_cycles;
    int first_ack;
    id = ID_W'(ID); fn = 4'd1; nbits = LEN_W'(4); wdata = 32'h6; req = 1'b1;
    dout = 1'b0;
    ack_cycles = 0; first_ack = -1;
    for (int e = 0; e < 60; e++) begin
      @(posedge clk); #1;
      if (e == 5) req = 1'b0;
      if (ack) begin
        ack_cycles++;
        if (first_ack < 0) first_ack = e;
      end
    end
    check("viol_ack_cycles", ack_cycles, 1);
    check("viol_ack_time", first_ack, 1 + 2 * CLK_DIV * 4);
    check("viol_ret", ret, 32'd0);
  endtask

  initial begin
    logic [3:0]  rfn;
    int          rn;
    int          sel;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {ack, sclk, din, rdata, ret}, '0);
    check("reset_state", dbg_state, ST_IDLE);
    rst = 1'b1;
    @(posedge clk); #1;

    run_req(ID_W'(ID), 4'd0, 8, 32'hA5, 32'h0, "wr8_a5");
    run_req(ID_W'(ID), 4'd1, 4, 32'hF, 32'b1001, "rw4");
    run_req(ID_W'(ID), 4'd0, 0, 32'h12, 32'h0, "len0");
    run_req(ID_W'(ID), 4'd0, 33, 32'h12, 32'h0, "len33");
    run_req(ID_W'(ID), 4'd7, 8, 32'h12, 32'h0, "badfn");
    run_skip(ID_W'(5), 30);
    run_req(ID_W'(ID), 4'd1, 8, 32'h3C, 32'h5A, "after_skip");
    run_reset_abort();
    run_req(ID_W'(ID), 4'd1, 16, 32'hBEEF, 32'hC3A5, "after_abort");
    run_violation();
    run_req(ID_W'(ID), 4'd1, 32, 32'hDEADBEEF, 32'h1234_5678, "rw32");
    run_req(ID_W'(ID), 4'd1, 1, 32'h1, 32'h1, "rw1");

    for (int t = 0; t < 20; t++) begin
      sel = $urandom_range(0, 9);
      rfn = (sel < 4) ? 4'd0 : (sel < 8) ? 4'd1 : 4'($urandom_range(2, 15));
      rn  = $urandom_range(0, 33);
      run_req(ID_W'(ID), rfn, rn, $urandom(), $urandom(), $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
